// File: rtl/bcd_scan_display.sv
// bcd_scan_display: captures a BCD count on a load strobe and scans it out
// to a time-multiplexed common-anode seven-segment display. New values are
// only applied at frame boundaries so a digit never changes mid-frame.
module bcd_scan_display #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  load,
    output logic                  load_ack,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  invalid
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } pend_state_t;

    pend_state_t           state_q, state_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   display_q, display_d;
    logic [4*DIGITS-1:0]   pending_q, pending_d;
    logic                  load_ack_q, load_ack_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  invalid_q, invalid_d;

    logic                  tick;
    logic                  frame_end;
    logic [3:0]            cur_digit;
    logic [DIGITS-1:0]     lz_blank;
    logic                  zero_run;
    logic                  cur_blank;

    // Prescaler divides the clock into scan slots; the index walks the digits.
    always_comb begin
        tick      = (pre_q == PRE_W'(SCAN_DIV - 1));
        pre_d     = tick ? '0 : pre_q + 1'b1;
        frame_end = tick && (idx_q == IDX_W'(DIGITS - 1));
        idx_d     = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Load capture and pending FSM; the old pending value wins a same-edge race.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        display_d  = display_q;
        load_ack_d = load;
        if (state_q == PENDING && frame_end) begin
            display_d = pending_q;
            state_d   = IDLE;
        end
        if (load) begin
            pending_d = bcd_in;
            state_d   = PENDING;
        end
    end

    // Decode the scanned digit with leading-zero blanking and flag non-BCD digits.
    always_comb begin
        cur_digit = 4'd0;
        an_d      = '0;
        invalid_d = 1'b0;
        lz_blank  = '0;
        zero_run  = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_digit = display_q[4*k +: 4];
                an_d[k]   = 1'b1;
            end
            if (display_q[4*k +: 4] > 4'd9) begin
                invalid_d = 1'b1;
            end
        end
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run    = zero_run && (display_q[4*k +: 4] == 4'd0);
            lz_blank[k] = zero_run && (k != 0);
        end
        cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_blank = blank_lz && lz_blank[k];
            end
        end
        case (cur_digit)
            4'd0:    seg_d = 7'b0111111;
            4'd1:    seg_d = 7'b0000110;
            4'd2:    seg_d = 7'b1011011;
            4'd3:    seg_d = 7'b1001111;
            4'd4:    seg_d = 7'b1100110;
            4'd5:    seg_d = 7'b1101101;
            4'd6:    seg_d = 7'b1111101;
            4'd7:    seg_d = 7'b0000111;
            4'd8:    seg_d = 7'b1111111;
            4'd9:    seg_d = 7'b1101111;
            default: seg_d = 7'b1000000;
        endcase
        if (cur_blank) begin
            seg_d = 7'b0000000;
        end
    end

    // State registers; reset blanks the display and drops any pending value.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            idx_q      <= '0;
            display_q  <= '0;
            pending_q  <= '0;
            load_ack_q <= 1'b0;
            seg_q      <= '0;
            an_q       <= '0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            display_q  <= display_d;
            pending_q  <= pending_d;
            load_ack_q <= load_ack_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            invalid_q  <= invalid_d;
        end
    end

    assign seg      = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign an       = (ACTIVE_LOW != 0) ? ~an_q : an_q;
    assign load_ack = load_ack_q;
    assign invalid  = invalid_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed testbench for bcd_scan_display with DIGITS=4, SCAN_DIV=4,
// ACTIVE_LOW=1. Expected pin patterns below are active-low constants.
module tb_bcd_scan_display;

    logic        clock;
    logic        reset;
    logic [15:0] bcd_in;
    logic        load;
    logic        load_ack;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        invalid;

    int checks;
    int errors;
    int edges;

    // Active-low segment patterns {g..a}
    localparam logic [6:0] P0 = 7'h40;
    localparam logic [6:0] P1 = 7'h79;
    localparam logic [6:0] P2 = 7'h24;
    localparam logic [6:0] P3 = 7'h30;
    localparam logic [6:0] P4 = 7'h19;
    localparam logic [6:0] P5 = 7'h12;
    localparam logic [6:0] P6 = 7'h02;
    localparam logic [6:0] P7 = 7'h78;
    localparam logic [6:0] P8 = 7'h00;
    localparam logic [6:0] PD = 7'h3F;
    localparam logic [6:0] PB = 7'h7F;

    bcd_scan_display #(
        .DIGITS(4),
        .SCAN_DIV(4),
        .ACTIVE_LOW(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bcd_in(bcd_in),
        .load(load),
        .load_ack(load_ack),
        .blank_lz(blank_lz),
        .seg(seg),
        .an(an),
        .invalid(invalid)
    );

    // 10 ns free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle just after it
    task automatic stepClock();
        @(posedge clock);
        #1;
        edges++;
    endtask

    task automatic stepTo(input int target);
        while (edges < target) stepClock();
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] value, input logic blank);
        load     = ld;
        bcd_in   = value;
        blank_lz = blank;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Step through one full frame checking every slot's anode, segments and invalid
    task automatic checkFrame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input logic inv);
        logic [6:0] pat [4];
        logic [3:0] an_exp;
        int slot;
        pat[0] = s0;
        pat[1] = s1;
        pat[2] = s2;
        pat[3] = s3;
        for (int i = 0; i < 16; i++) begin
            stepClock();
            slot   = i / 4;
            an_exp = ~(4'b0001 << slot);
            checkOutput($sformatf("%s_an_e%0d", tag, i), {12'd0, an}, {12'd0, an_exp});
            checkOutput($sformatf("%s_seg_e%0d", tag, i), {9'd0, seg}, {9'd0, pat[slot]});
            checkOutput($sformatf("%s_inv_e%0d", tag, i), {15'd0, invalid}, {15'd0, inv});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        edges  = 0;
        reset  = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b1);

        // Reset state
        stepClock();
        stepClock();
        checkOutput("rst_seg", {9'd0, seg}, 16'h007F);
        checkOutput("rst_an", {12'd0, an}, 16'h000F);
        checkOutput("rst_ack", {15'd0, load_ack}, 16'h0000);
        checkOutput("rst_inv", {15'd0, invalid}, 16'h0000);

        // Idle frame after release: digit 0 shows '0', the rest blanked
        reset = 1'b1;
        edges = 0;
        checkFrame("idle", P0, PB, PB, PB, 1'b0);

        // Mid-frame load at idx=1, applied only at the next boundary
        stepTo(20);
        applyStimulus(1'b1, 16'h1234, 1'b1);
        stepClock();
        checkOutput("ack1234", {15'd0, load_ack}, 16'h0001);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        stepClock();
        checkOutput("ack1234_drop", {15'd0, load_ack}, 16'h0000);
        stepTo(25);
        checkOutput("hold_an", {12'd0, an}, 16'h000B);
        checkOutput("hold_seg", {9'd0, seg}, {9'd0, PB});
        stepTo(32);
        checkFrame("f1234", P4, P3, P2, P1, 1'b0);

        // Two loads in one frame: the last one wins
        stepTo(50);
        applyStimulus(1'b1, 16'h1111, 1'b1);
        stepClock();
        checkOutput("ack1111", {15'd0, load_ack}, 16'h0001);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        stepClock();
        checkOutput("ack_gap", {15'd0, load_ack}, 16'h0000);
        applyStimulus(1'b1, 16'h5678, 1'b1);
        stepClock();
        checkOutput("ack5678", {15'd0, load_ack}, 16'h0001);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        stepTo(64);
        checkFrame("f5678", P8, P7, P6, P5, 1'b0);

        // Non-BCD digit with leading-zero blanking
        applyStimulus(1'b1, 16'h00A5, 1'b1);
        stepClock();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        stepTo(96);
        checkOutput("inv_apply_edge", {15'd0, invalid}, 16'h0000);
        checkFrame("f00A5", P5, PD, PB, PB, 1'b1);

        // Leading zeros shown when blanking is off
        applyStimulus(1'b1, 16'h0007, 1'b0);
        stepClock();
        applyStimulus(1'b0, 16'h0000, 1'b0);
        stepTo(128);
        checkOutput("inv_still_set", {15'd0, invalid}, 16'h0001);
        checkFrame("f0007", P7, P0, P0, P0, 1'b0);

        // Pending value dropped by reset before the boundary
        applyStimulus(1'b1, 16'h4321, 1'b1);
        stepClock();
        checkOutput("ack4321", {15'd0, load_ack}, 16'h0001);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        stepTo(150);
        applyStimulus(1'b1, 16'h9999, 1'b1);
        reset = 1'b0;
        stepClock();
        checkOutput("rst2_seg", {9'd0, seg}, 16'h007F);
        checkOutput("rst2_an", {12'd0, an}, 16'h000F);
        checkOutput("rst2_ack", {15'd0, load_ack}, 16'h0000);
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b1);
        edges = 0;
        checkFrame("post_rst_a", P0, PB, PB, PB, 1'b0);
        checkFrame("post_rst_b", P0, PB, PB, PB, 1'b0);

        // Load and frame boundary on the same edge
        applyStimulus(1'b1, 16'h1111, 1'b1);
        stepClock();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        stepTo(47);
        applyStimulus(1'b1, 16'h2222, 1'b1);
        stepClock();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkFrame("race_old", P1, P1, P1, P1, 1'b0);
        checkFrame("race_new", P2, P2, P2, P2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of the cascaded T-flip-flop BCD counter chain.
- Captures a multi-digit BCD count on a load strobe and drives a time-multiplexed common-anode seven-segment display, one digit per scan slot.
- Decodes the value with optional leading-zero blanking and flags non-BCD digits.
- New values are applied only at frame boundaries, so a digit never tears mid-frame.

Parameters:
- DIGITS, 4, number of BCD digits / anode lines (1..8).
- SCAN_DIV, 1000, clock cycles per digit scan slot (>=1).
- ACTIVE_LOW, 1, 1 = seg and an pins active-low; 0 = active-high.

Ports:
- clock  input  1  single system clock, all logic on posedge.
- reset  input  1  synchronous, active-low reset, sampled on posedge clock.
- bcd_in  input  4*DIGITS  BCD value; digit k = bcd_in[4k+3:4k], digit 0 is least significant.
- load  input  1  capture strobe; bcd_in is sampled on any edge where load=1.
- load_ack  output  1  one-cycle pulse acknowledging a capture.
- blank_lz  input  1  1 = blank leading zeros.
- seg  output  7  segments {g,f,e,d,c,b,a}.
- an  output  DIGITS  anode enables, one-hot active.
- invalid  output  1  high while any displayed digit is greater than 9.

Behaviour:
- Reset (reset=0 at an edge):
  - display_reg=0, pending_reg=0, pend_flag=0, prescaler=0, idx=0.
  - Outputs blank (seg and an all inactive), load_ack=0, invalid=0.
  - A pending value is discarded.
- Prescaler:
  - Counts 0..SCAN_DIV-1; tick=1 when prescaler==SCAN_DIV-1, then it wraps to 0.
  - SCAN_DIV=1 means tick every cycle.
- Scan index:
  - idx (clog2(DIGITS) bits, minimum 1) advances on tick: 0,1,...,DIGITS-1,0.
  - A frame boundary is a tick with idx==DIGITS-1.
- Load handshake:
  - On an edge with load=1: pending_reg<=bcd_in, pend_flag<=1, load_ack<=1 for exactly the next cycle.
  - Load held high for N cycles gives N captures and N ack cycles.
  - Multiple loads within one frame: the last one wins.
- Pending FSM:
  - IDLE (pend_flag=0): load -> PENDING.
  - PENDING: at a frame boundary, display_reg<=pending_reg and return to IDLE.
  - Load and frame boundary on the same edge: display_reg takes the old pending_reg; the new bcd_in goes to pending_reg and the FSM stays PENDING.
- Decode (registered, 1-cycle latency from idx/display_reg to pins):
  - Active-high patterns {g..a}: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Values 10..15 show dash (1000000) and are never blanked.
- Leading-zero blanking (blank_lz=1):
  - Digit k is blanked if it and every digit above it are 0.
  - Digit 0 is never blanked.
  - A blanked digit drives seg all off but its an line is still driven, keeping duty uniform.
- an: one-hot on idx; exactly one line is active at all times after the first post-reset edge.
- invalid: registered; 1 when any digit of display_reg > 9; updates 1 cycle after display_reg changes.
- Polarity: ACTIVE_LOW=1 inverts seg and an at the pins only. Reset-blank therefore means seg=7'h7F and an all ones.

Test Plan:
- Reset then idle, ACTIVE_LOW=1, SCAN_DIV=4, blank_lz=1 -> first edge after release: an=1110, seg=1000000; an=1101/1011/0111 each with seg=1111111; an steps every 4 cycles.
- Mid-frame at idx=1, load=1 with bcd_in=16'h1234 -> load_ack=1 next cycle; display stays 0 until the boundary after idx=3. Next frame shows digit0 '4' 0011001, d1 '3' 0110000, d2 '2' 0100100, d3 '1' 1111001.
- Two loads in one frame (16'h1111 then 16'h5678) -> next frame shows 5678; two load_ack pulses.
- Load 16'h00A5 with blank_lz=1 -> d3 and d2 blank, d1 dash 0111111, d0 '5' 0010010; invalid=1 one cycle after the apply edge.
- Load 16'h0007 with blank_lz=0 -> 0007 shown: digits 3..1 show 1000000, digit 0 shows 1111000; invalid=0.
- Load pending, then reset=0 for one edge before the boundary -> next edge: seg=1111111, an=1111, load_ack=0. After release, display shows 0 (pending dropped) and idx restarts at 0.
